dac_out_buffer: RTL and testbench
=================================

Name: dac_out_buffer

Overview:
Transmit-side counterpart of the ADC capture path. The block accepts DAC sample words from the demodulation/control logic over a valid/ready handshake and buffers them in a small synchronous FIFO. It releases one sample to the DAC output register per programmable update period, and holds the last value while reporting underflow when the producer falls behind. It runs in a single clock domain (CPU/control clock) and feeds the DAC pin register stage.

Parameters:
DATA_WIDTH, 14, DAC sample width
DEPTH, 16, FIFO depth in words; power of two, at least 2
DIV_WIDTH, 16, width of update-period divider
IDLE_CODE, 14'h2000, output code after reset (midscale, offset binary)

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_enable  input  1  1 = divider runs and samples are released; 0 = divider held, no pops
i_flush  input  1  synchronous FIFO clear, single-cycle or level
i_div  input  DIV_WIDTH  update period = i_div+1 clock cycles
i_data_wr  input  DATA_WIDTH  sample from producer
i_valid_wr  input  1  producer sample valid
o_ready_wr  output  1  FIFO can accept; push = i_valid_wr & o_ready_wr
o_dac_data  output  DATA_WIDTH  registered DAC code
o_dac_strobe  output  1  one-cycle pulse, high in the cycle o_dac_data takes a new FIFO word
o_underflow  output  1  one-cycle pulse on an update tick with an empty FIFO
o_underflow_cnt  output  16  saturating underflow count
o_level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, i_rst_n=0):
  - pointers, o_level, divider counter, o_underflow_cnt = 0
  - o_dac_data = IDLE_CODE
  - o_dac_strobe = 0, o_underflow = 0
  - o_ready_wr = 0 while in reset; goes to 1 on the first clock after release
  - Reset mid-operation discards all buffered data.
- o_ready_wr = !full & !i_flush (combinational from registered level and i_flush).
- Divider:
  - Counter cnt runs 0..div_lat, then wraps to 0. tick = i_enable & (cnt == div_lat).
  - div_lat is loaded from i_div at reset release, on every tick, and while i_enable=0.
  - A change to i_div mid-period therefore takes effect after the current period.
  - i_enable=0 holds cnt at 0. After i_enable rises, the first tick occurs exactly i_div+1 cycles later.
  - i_div=0 gives a tick every enabled cycle.
- On tick, not empty:
  - Pop the head word. At the next edge, o_dac_data = head and o_dac_strobe = 1 for one cycle.
- On tick, empty:
  - o_dac_data holds, o_dac_strobe = 0, o_underflow = 1 for one cycle.
  - o_underflow_cnt increments, saturating at 16'hFFFF.
- No bypass: a word pushed in cycle t is poppable at the earliest by a tick in cycle t+1.
- Simultaneous push and pop (0 < level < DEPTH): both occur and o_level is unchanged.
  - Push into an empty FIFO on a tick cycle: the tick counts as underflow and the word stays buffered.
- Full: o_ready_wr=0. Producer valid with ready low is not an error; the producer holds the data.
  - A pop while full raises o_ready_wr in the next cycle.
- Flush (i_flush=1):
  - pointers and o_level clear at the edge; divider cnt clears to 0.
  - o_dac_data holds its value; o_underflow_cnt is not cleared.
  - No push or pop takes effect in a flush cycle. A tick coinciding with flush is suppressed (no strobe, no underflow).
- Pointers wrap modulo DEPTH, using an extra MSB for full/empty detection.
- o_level is exact every cycle, in the range 0..DEPTH.

Test Plan:
- Reset/idle: hold i_rst_n=0 for 5 cycles and release with i_enable=0 -> o_dac_data=14'h2000, o_ready_wr=1 from the first post-reset cycle, o_level=0, no strobes for 100 cycles.
- Steady stream: i_div=3, push 8 words 0x0001..0x0008 back-to-back, then enable -> strobes exactly every 4 cycles with first strobe 4 cycles after the enable edge, o_dac_data sequence 1..8, o_underflow_cnt=0.
- Underflow: after the stream drains with 3 further ticks -> 3 o_underflow pulses, o_underflow_cnt=3, o_dac_data stays 0x0008; force 70000 underflows -> count saturates at 0xFFFF.
- Full/backpressure: i_enable=0, i_valid_wr held high with incrementing data for 20 cycles -> exactly 16 words accepted, o_level=16, o_ready_wr=0. Enable with i_div=0 -> 16 words out in order, with o_ready_wr reasserting the cycle after the first pop.
- Flush and div change: with 5 words buffered, pulse i_flush -> o_level=0 next cycle, o_dac_data unchanged, no strobe. Change i_div 3->7 mid-period -> current period ends at 4 cycles, subsequent periods are 8 cycles.
- Async reset mid-stream: assert i_rst_n=0 between clock edges with 10 words buffered -> outputs reset immediately to IDLE_CODE/0 without a clock edge, and o_level=0.

Source files
------------

// File: rtl/dac_out_buffer.sv
// DAC output buffer: samples arrive over valid/ready into a small FIFO and are
// released one per programmable update period into the registered DAC code.
module dac_out_buffer #(
  parameter int unsigned           DATA_WIDTH = 14,
  parameter int unsigned           DEPTH      = 16,
  parameter int unsigned           DIV_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] IDLE_CODE  = 14'h2000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic                    i_flush,
  input  logic [DIV_WIDTH-1:0]    i_div,
  input  logic [DATA_WIDTH-1:0]   i_data_wr,
  input  logic                    i_valid_wr,
  output logic                    o_ready_wr,
  output logic [DATA_WIDTH-1:0]   o_dac_data,
  output logic                    o_dac_strobe,
  output logic                    o_underflow,
  output logic [15:0]             o_underflow_cnt,
  output logic [$clog2(DEPTH):0]  o_level
);

  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam int unsigned   LW      = AW + 1;
  localparam logic [15:0]   CNT_MAX = 16'hFFFF;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  active_q;
  logic [LW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]  div_lat_q, div_lat_d;
  logic [DATA_WIDTH-1:0] dac_q, dac_d;
  logic                  strobe_q, strobe_d;
  logic                  unf_q, unf_d;
  logic [15:0]           unf_cnt_q, unf_cnt_d;

  logic                  tick_s;
  logic                  upd_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  ready_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  unf_evt_s;

  // Set on the first clock after reset release; gates ready and the first divider load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
    end
  end

  // Update-period divider; the period latch only reloads at a period boundary or while idle.
  always_comb begin
    tick_s    = i_enable & active_q & (cnt_q == div_lat_q);
    cnt_d     = cnt_q;
    div_lat_d = div_lat_q;
    if (!active_q || !i_enable || i_flush) begin
      cnt_d = '0;
    end else if (tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
    if (!active_q || !i_enable || tick_s) begin
      div_lat_d = i_div;
    end else begin
      div_lat_d = div_lat_q;
    end
  end

  // FIFO status and handshake; full/empty come from the wrap bit of the pointers.
  always_comb begin
    empty_s   = (wr_ptr_q == rd_ptr_q);
    full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    ready_s   = active_q & ~full_s & ~i_flush;
    push_s    = i_valid_wr & ready_s;
    upd_s     = tick_s & ~i_flush;
    pop_s     = upd_s & ~empty_s;
    unf_evt_s = upd_s & empty_s;
  end

  // Pointer and occupancy next state; flush wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + LW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + LW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // DAC code, strobe and underflow next state; the code holds when nothing is popped.
  always_comb begin
    dac_d     = dac_q;
    strobe_d  = pop_s;
    unf_d     = unf_evt_s;
    unf_cnt_d = unf_cnt_q;
    if (pop_s) begin
      dac_d = mem_q[rd_ptr_q[AW-1:0]];
    end else begin
      dac_d = dac_q;
    end
    if (unf_evt_s && (unf_cnt_q != CNT_MAX)) begin
      unf_cnt_d = unf_cnt_q + 16'd1;
    end else begin
      unf_cnt_d = unf_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      cnt_q     <= '0;
      div_lat_q <= '0;
      dac_q     <= IDLE_CODE;
      strobe_q  <= 1'b0;
      unf_q     <= 1'b0;
      unf_cnt_q <= 16'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      div_lat_q <= div_lat_d;
      dac_q     <= dac_d;
      strobe_q  <= strobe_d;
      unf_q     <= unf_d;
      unf_cnt_q <= unf_cnt_d;
    end
  end

  // Sample storage; no reset needed since occupancy alone defines valid entries.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_data_wr;
    end
  end

  assign o_ready_wr      = ready_s;
  assign o_dac_data      = dac_q;
  assign o_dac_strobe    = strobe_q;
  assign o_underflow     = unf_q;
  assign o_underflow_cnt = unf_cnt_q;
  assign o_level         = level_q;

endmodule

// File: tb/tb_dac_out_buffer.sv
// Directed self-checking bench for dac_out_buffer: inputs are driven and
// outputs sampled on the falling clock edge.
module tb_dac_out_buffer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        flush;
  logic [15:0] div;
  logic [13:0] data_wr;
  logic        valid_wr;
  logic        ready_wr;
  logic [13:0] dac_data;
  logic        dac_strobe;
  logic        underflow;
  logic [15:0] underflow_cnt;
  logic [4:0]  level;

  int n_tests;
  int n_fail;

  dac_out_buffer dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_enable        (enable),
    .i_flush         (flush),
    .i_div           (div),
    .i_data_wr       (data_wr),
    .i_valid_wr      (valid_wr),
    .o_ready_wr      (ready_wr),
    .o_dac_data      (dac_data),
    .o_dac_strobe    (dac_strobe),
    .o_underflow     (underflow),
    .o_underflow_cnt (underflow_cnt),
    .o_level         (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    int strobes;
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; div = 16'd3;
    data_wr = 14'd0; valid_wr = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (ready_wr !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready_wr); end
    n_tests++; if (dac_data !== 14'h2000) begin n_fail++; $display("FAIL reset_dac: got %h expected 2000", dac_data); end
    n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_tests++; if ({dac_strobe, underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {dac_strobe, underflow}); end
    n_tests++; if (underflow_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_ucnt: got %h expected 0000", underflow_cnt); end
    rst_n = 1'b1;
    #1;
    n_tests++; if (ready_wr !== 1'b0) begin n_fail++; $display("FAIL ready_before_clk: got %b expected 0", ready_wr); end
    @(negedge clk);
    n_tests++; if (ready_wr !== 1'b1) begin n_fail++; $display("FAIL ready_first_clk: got %b expected 1", ready_wr); end
    strobes = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dac_strobe === 1'b1 || underflow === 1'b1) strobes++;
    end
    n_tests++; if (strobes !== 0) begin n_fail++; $display("FAIL idle_strobes: got %0d expected 0", strobes); end
    n_tests++; if (dac_data !== 14'h2000) begin n_fail++; $display("FAIL idle_dac: got %h expected 2000", dac_data); end
  endtask

  task automatic test_stream();
    logic       exp_strobe;
    logic       exp_unf;
    logic [13:0] exp_data;
    div = 16'd3;
    for (int k = 1; k <= 8; k++) begin
      valid_wr = 1'b1; data_wr = 14'(k);
      @(negedge clk);
    end
    valid_wr = 1'b0;
    n_tests++; if (level !== 5'd8) begin n_fail++; $display("FAIL stream_level: got %0d expected 8", level); end
    enable = 1'b1;
    exp_data = 14'h2000;
    for (int n = 1; n <= 44; n++) begin
      @(negedge clk);
      exp_strobe = (n % 4 == 0) && (n <= 32);
      exp_unf    = (n % 4 == 0) && (n > 32);
      if (exp_strobe) exp_data = 14'(n / 4);
      n_tests++; if (dac_strobe !== exp_strobe) begin n_fail++; $display("FAIL stream_strobe n=%0d: got %b expected %b", n, dac_strobe, exp_strobe); end
      n_tests++; if (underflow !== exp_unf) begin n_fail++; $display("FAIL stream_unf n=%0d: got %b expected %b", n, underflow, exp_unf); end
      n_tests++; if (dac_data !== exp_data) begin n_fail++; $display("FAIL stream_data n=%0d: got %h expected %h", n, dac_data, exp_data); end
      if (n == 32) begin
        n_tests++; if (underflow_cnt !== 16'd0) begin n_fail++; $display("FAIL stream_ucnt: got %0d expected 0", underflow_cnt); end
      end
    end
    enable = 1'b0;
    n_tests++; if (underflow_cnt !== 16'd3) begin n_fail++; $display("FAIL unf_count3: got %0d expected 3", underflow_cnt); end
  endtask

  task automatic test_underflow_saturate();
    div = 16'd0;
    @(negedge clk);
    enable = 1'b1;
    repeat (70000) @(negedge clk);
    n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL sat_pulse: got %b expected 1", underflow); end
    enable = 1'b0;
    n_tests++; if (underflow_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_count: got %h expected ffff", underflow_cnt); end
    n_tests++; if (dac_data !== 14'h0008) begin n_fail++; $display("FAIL sat_dac_hold: got %h expected 0008", dac_data); end
    @(negedge clk);
    n_tests++; if (underflow_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_count_hold: got %h expected ffff", underflow_cnt); end
  endtask

  task automatic test_full_backpressure();
    logic exp_ready;
    div = 16'd0;
    valid_wr = 1'b1; data_wr = 14'h100;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_ready = (k < 16);
      n_tests++; if (ready_wr !== exp_ready) begin n_fail++; $display("FAIL full_ready k=%0d: got %b expected %b", k, ready_wr, exp_ready); end
      data_wr = 14'(14'h100 + k);
    end
    valid_wr = 1'b0;
    n_tests++; if (level !== 5'd16) begin n_fail++; $display("FAIL full_level: got %0d expected 16", level); end
    enable = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      n_tests++; if (dac_strobe !== 1'b1) begin n_fail++; $display("FAIL drain_strobe n=%0d: got %b expected 1", n, dac_strobe); end
      n_tests++; if (dac_data !== 14'(14'h100 + n - 1)) begin n_fail++; $display("FAIL drain_data n=%0d: got %h expected %h", n, dac_data, 14'(14'h100 + n - 1)); end
      n_tests++; if (level !== 5'(16 - n)) begin n_fail++; $display("FAIL drain_level n=%0d: got %0d expected %0d", n, level, 16 - n); end
      if (n == 1) begin
        n_tests++; if (ready_wr !== 1'b1) begin n_fail++; $display("FAIL ready_after_pop: got %b expected 1", ready_wr); end
      end
    end
    enable = 1'b0;
    @(negedge clk);
    n_tests++; if (dac_strobe !== 1'b0) begin n_fail++; $display("FAIL drain_done_strobe: got %b expected 0", dac_strobe); end
  endtask

  task automatic test_flush_div();
    logic exp_unf;
    div = 16'd3;
    for (int k = 0; k < 5; k++) begin
      valid_wr = 1'b1; data_wr = 14'(14'h200 + k);
      @(negedge clk);
    end
    valid_wr = 1'b0;
    n_tests++; if (level !== 5'd5) begin n_fail++; $display("FAIL flush_pre_level: got %0d expected 5", level); end
    flush = 1'b1;
    #1;
    n_tests++; if (ready_wr !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b expected 0", ready_wr); end
    @(negedge clk);
    flush = 1'b0;
    n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL flush_level: got %0d expected 0", level); end
    n_tests++; if (dac_data !== 14'h10F) begin n_fail++; $display("FAIL flush_dac_hold: got %h expected 010f", dac_data); end
    n_tests++; if (dac_strobe !== 1'b0) begin n_fail++; $display("FAIL flush_strobe: got %b expected 0", dac_strobe); end
    // Tick coinciding with flush: one buffered word, period of one cycle.
    div = 16'd0;
    valid_wr = 1'b1; data_wr = 14'h300;
    @(negedge clk);
    valid_wr = 1'b0;
    n_tests++; if (level !== 5'd1) begin n_fail++; $display("FAIL flush_tick_pre: got %0d expected 1", level); end
    enable = 1'b1; flush = 1'b1;
    @(negedge clk);
    enable = 1'b0; flush = 1'b0;
    n_tests++; if ({dac_strobe, underflow} !== 2'b00) begin n_fail++; $display("FAIL flush_tick_pulses: got %b expected 00", {dac_strobe, underflow}); end
    n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL flush_tick_level: got %0d expected 0", level); end
    n_tests++; if (dac_data !== 14'h10F) begin n_fail++; $display("FAIL flush_tick_dac: got %h expected 010f", dac_data); end
    // Period change mid-period, ticks observed as underflow pulses on an empty FIFO.
    div = 16'd3;
    @(negedge clk);
    enable = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 2) div = 16'd7;
      exp_unf = (n == 4) || (n == 12) || (n == 20);
      n_tests++; if (underflow !== exp_unf) begin n_fail++; $display("FAIL div_change n=%0d: got %b expected %b", n, underflow, exp_unf); end
    end
    enable = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 10; k++) begin
      valid_wr = 1'b1; data_wr = 14'(14'h400 + k);
      @(negedge clk);
    end
    valid_wr = 1'b0;
    n_tests++; if (level !== 5'd10) begin n_fail++; $display("FAIL areset_pre_level: got %0d expected 10", level); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (dac_data !== 14'h2000) begin n_fail++; $display("FAIL areset_dac: got %h expected 2000", dac_data); end
    n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL areset_level: got %0d expected 0", level); end
    n_tests++; if (underflow_cnt !== 16'd0) begin n_fail++; $display("FAIL areset_ucnt: got %h expected 0000", underflow_cnt); end
    n_tests++; if (ready_wr !== 1'b0) begin n_fail++; $display("FAIL areset_ready: got %b expected 0", ready_wr); end
    n_tests++; if ({dac_strobe, underflow} !== 2'b00) begin n_fail++; $display("FAIL areset_pulses: got %b expected 00", {dac_strobe, underflow}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL areset_post_level: got %0d expected 0", level); end
    n_tests++; if (ready_wr !== 1'b1) begin n_fail++; $display("FAIL areset_post_ready: got %b expected 1", ready_wr); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_stream();
    test_underflow_saturate();
    test_full_backpressure();
    test_flush_div();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
